// File: rtl/fp_addsub_seq.sv
// Iterative single-precision add/subtract: one operand pair at a time,
// bit-serial alignment and normalization, truncating, result held until taken.
module fp_addsub_seq #(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [EXP_WIDTH+MAN_WIDTH:0] op_a,
   input  logic [EXP_WIDTH+MAN_WIDTH:0] op_b,
   input  logic                         operation_select,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXP_WIDTH+MAN_WIDTH:0] result,
   output logic [2:0]                   flags,
   output logic                         busy
);
   localparam int W  = EXP_WIDTH + MAN_WIDTH + 1;
   localparam int MW = MAN_WIDTH + 2;
   localparam int CW = $clog2(MAN_WIDTH + 3);
   localparam logic [EXP_WIDTH-1:0] SAT_SHIFT = EXP_WIDTH'(MAN_WIDTH + 2);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

   state_t               state_q, state_d;
   logic                 sign_q, sign_d;
   logic                 sub_q, sub_d;
   logic [EXP_WIDTH-1:0] exp_q, exp_d;
   logic [MW-1:0]        big_q, big_d;
   logic [MW-1:0]        small_q, small_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [W-1:0]         result_q, result_d;
   logic [2:0]           flags_q, flags_d;

   logic [EXP_WIDTH-1:0] exp_a, exp_b, exp_diff, exp_inc;
   logic [MAN_WIDTH-1:0] man_a, man_b;
   logic [MW-1:0]        mant_a, mant_b, sum;
   logic                 sign_a, sign_b_eff, a_max, b_max, a_nan, b_nan;
   logic                 special_inv, a_big;

   // Operand decode; denormals become signed zero by dropping the hidden bit.
   always_comb begin
      sign_a      = op_a[W-1];
      sign_b_eff  = op_b[W-1] ~^ operation_select;
      exp_a       = op_a[W-2:MAN_WIDTH];
      exp_b       = op_b[W-2:MAN_WIDTH];
      man_a       = op_a[MAN_WIDTH-1:0];
      man_b       = op_b[MAN_WIDTH-1:0];
      mant_a      = (exp_a == '0) ? '0 : {2'b01, man_a};
      mant_b      = (exp_b == '0) ? '0 : {2'b01, man_b};
      a_max       = (exp_a == '1);
      b_max       = (exp_b == '1);
      a_nan       = a_max && (man_a != '0);
      b_nan       = b_max && (man_b != '0);
      special_inv = a_nan || b_nan || (a_max && b_max && (sign_a != sign_b_eff));
      a_big       = (exp_a > exp_b) || ((exp_a == exp_b) && (mant_a >= mant_b));
      exp_diff    = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
   end

   assign sum     = sub_q ? (big_q - small_q) : (big_q + small_q);
   assign exp_inc = exp_q + EXP_WIDTH'(1);

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      sub_d    = sub_q;
      exp_d    = exp_q;
      big_d    = big_q;
      small_d  = small_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (a_max || b_max) begin
                  result_d = special_inv ? QNAN
                           : {(a_max ? sign_a : sign_b_eff), {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                  flags_d  = {1'b0, special_inv, 1'b0};
                  state_d  = S_DONE;
               end else begin
                  sign_d  = a_big ? sign_a : sign_b_eff;
                  sub_d   = sign_a ^ sign_b_eff;
                  exp_d   = a_big ? exp_a : exp_b;
                  big_d   = a_big ? mant_a : mant_b;
                  small_d = a_big ? mant_b : mant_a;
                  cnt_d   = (exp_diff > SAT_SHIFT) ? CW'(MAN_WIDTH + 2) : CW'(exp_diff);
                  state_d = (exp_diff == '0) ? S_ADD : S_ALIGN;
               end
            end
         end
         S_ALIGN: begin
            small_d = small_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_ADD;
         end
         S_ADD: begin
            if (sum == '0) begin
               result_d = '0;
               flags_d  = '0;
               state_d  = S_DONE;
            end else if (sum[MW-1]) begin
               big_d = sum >> 1;
               exp_d = exp_inc;
               if (exp_inc == '1) begin
                  result_d = {sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                  flags_d  = 3'b001;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_NORM;
               end
            end else begin
               big_d   = sum;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            if (big_q[MAN_WIDTH]) begin
               result_d = {sign_q, exp_q, big_q[MAN_WIDTH-1:0]};
               flags_d  = '0;
               state_d  = S_DONE;
            end else if (exp_q > EXP_WIDTH'(1)) begin
               big_d = big_q << 1;
               exp_d = exp_q - EXP_WIDTH'(1);
            end else begin
               result_d = '0;
               flags_d  = 3'b100;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         sub_q    <= 1'b0;
         exp_q    <= '0;
         big_q    <= '0;
         small_q  <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         sub_q    <= sub_d;
         exp_q    <= exp_d;
         big_q    <= big_d;
         small_q  <= small_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed cases plus random pairs
// checked against an arithmetic reference model, with latency and hold checks.
module tb_fp_addsub_seq;
   logic        clk, rst_n, in_valid, in_ready, operation_select;
   logic        out_valid, out_ready, busy;
   logic [31:0] op_a, op_b, result;
   logic [2:0]  flags;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  fl;
      int unsigned lat;
      int unsigned stamp;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   bit          bp_mode = 0;

   fp_addsub_seq #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .operation_select(operation_select),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flags(flags), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
      end
   endfunction

   function automatic void fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s at cycle %0d", nm, cyc);
   endfunction

   // Reference: decode, flush, align by the saturated distance, add, normalize.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 output logic [31:0] r, output logic [2:0] f, output int unsigned l);
      int ea, eb, eB, eS, e, sh, n;
      longint va, vb, vB, vS, s;
      logic sa, sbe, sB;
      logic [22:0] ma, mb;
      logic [31:0] tmp;
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      ma = a[22:0];        mb = b[22:0];
      sa = a[31];          sbe = ~(b[31] ^ op);
      f = 3'b000;
      if (ea == 255 || eb == 255) begin
         l = 1;
         if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) || (ea == 255 && eb == 255 && sa != sbe)) begin
            r = 32'h7FC00000;
            f = 3'b010;
         end else begin
            r = {((ea == 255) ? sa : sbe), 8'hFF, 23'h0};
         end
         return;
      end
      va = (ea == 0) ? 0 : (longint'(ma) + (longint'(1) << 23));
      vb = (eb == 0) ? 0 : (longint'(mb) + (longint'(1) << 23));
      if (ea > eb || (ea == eb && va >= vb)) begin
         eB = ea; vB = va; sB = sa;  eS = eb; vS = vb;
      end else begin
         eB = eb; vB = vb; sB = sbe; eS = ea; vS = va;
      end
      sh = eB - eS;
      if (sh > 25) sh = 25;
      vS = vS >> sh;
      s = (sa == sbe) ? (vB + vS) : (vB - vS);
      if (s == 0) begin
         r = 32'h0; l = sh + 2;
         return;
      end
      e = eB;
      if (s >= (longint'(1) << 24)) begin
         s = s >> 1;
         e++;
         if (e == 255) begin
            r = {sB, 8'hFF, 23'h0}; f = 3'b001; l = sh + 2;
            return;
         end
      end
      n = 0;
      while (s < (longint'(1) << 23)) begin
         if (e > 1) begin
            s = s << 1; e--; n++;
         end else begin
            r = 32'h0; f = 3'b100; l = sh + n + 3;
            return;
         end
      end
      tmp = 32'(s);
      r = {sB, 8'(e), tmp[22:0]};
      l = sh + n + 3;
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] r, input logic [2:0] f, input int unsigned l);
      exp_t e;
      bit ok = 0;
      @(negedge clk);
      op_a = a; op_b = b; operation_select = op; in_valid = 1'b1;
      for (int t = 0; t < 400; t++) begin
         if (in_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         fail_now("issue_timeout");
         in_valid = 1'b0;
         return;
      end
      e.res = r; e.fl = f; e.lat = l; e.stamp = cyc;
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
      op_a = $urandom; op_b = $urandom;
   endtask

   task automatic wait_idle;
      bit ok = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid && in_ready) begin ok = 1; break; end
      end
      if (!ok) fail_now("drain_timeout");
   endtask

   task automatic rand_pair(output logic [31:0] a, output logic [31:0] b, output logic op);
      int ea, eb, k;
      logic [22:0] ma, mb;
      logic [31:0] t;
      ea = int'($urandom_range(1, 254));
      ma = 23'($urandom); mb = 23'($urandom);
      k  = int'($urandom_range(0, 9));
      case (k)
         0: eb = 0;
         1: begin
            eb = 255;
            if ($urandom_range(0, 1) == 0) mb = '0;
            if ($urandom_range(0, 2) == 0) begin
               ea = 255;
               if ($urandom_range(0, 1) == 0) ma = '0;
            end
         end
         2: begin eb = ea; mb = ma; end
         3: begin eb = ea; mb = ma ^ (23'(1) << $urandom_range(0, 22)); end
         4: begin ea = int'($urandom_range(1, 4)); eb = int'($urandom_range(1, 4)); end
         5: begin ea = 254; eb = int'($urandom_range(250, 254)); end
         default: begin
            eb = ea + int'($urandom_range(0, 8)) - 4;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
         end
      endcase
      a = {1'($urandom), 8'(ea), ma};
      b = {1'($urandom), 8'(eb), mb};
      if ($urandom_range(0, 1) == 0) begin t = a; a = b; b = t; end
      op = 1'($urandom);
   endtask

   // Consumer: random acceptance, or three refused DONE cycles in backpressure mode.
   initial begin
      int vcnt = 0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (out_valid) vcnt++; else vcnt = 0;
         out_ready = bp_mode ? (vcnt > 3) : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on the first cycle of each result.
   initial begin
      exp_t cur;
      bit have_cur = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            have_cur = 0;
         end else if (out_valid) begin
            if (!have_cur) begin
               if (sb.size() == 0) begin
                  fail_now("unexpected_result");
               end else begin
                  cur = sb.pop_front();
                  have_cur = 1;
                  chk("latency", cyc - cur.stamp, cur.lat);
                  chk("result", result, cur.res);
                  chk("flags", {29'h0, flags}, {29'h0, cur.fl});
               end
            end else begin
               chk("hold_result", result, cur.res);
               chk("hold_flags", {29'h0, flags}, {29'h0, cur.fl});
            end
            chk("in_ready_done", {31'h0, in_ready}, 32'h0);
            chk("busy_done", {31'h0, busy}, 32'h1);
            if (out_ready) have_cur = 0;
         end else begin
            if (have_cur) begin
               fail_now("valid_dropped");
               have_cur = 0;
            end
            if (sb.size() != 0) begin
               chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
               chk("busy_busy", {31'h0, busy}, 32'h1);
            end else begin
               chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
               chk("busy_idle", {31'h0, busy}, 32'h0);
            end
         end
      end
   end

   initial begin
      logic [31:0] a, b, r;
      logic [2:0]  f;
      logic        op;
      int unsigned l;
      rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; operation_select = 1'b0;
      #12;
      chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
      chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_result", result, 32'h0);
      chk("reset_flags", {29'h0, flags}, 32'h0);
      @(posedge clk); #3 rst_n = 1'b1;

      issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 3);
      wait_idle();
      issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000, 2);
      issue(32'h3FC00000, 32'h3FA00000, 1'b0, 32'h3E800000, 3'b000, 5);
      issue(32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 3'b000, 28);
      issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 3'b001, 2);
      issue(32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000, 3'b010, 1);
      wait_idle();

      bp_mode = 1;
      issue(32'h40400000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);
      wait_idle();
      bp_mode = 0;

      issue(32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 3'b000, 28);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
      chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_result", result, 32'h0);
      chk("abort_flags", {29'h0, flags}, 32'h0);
      @(negedge clk); @(negedge clk);
      @(posedge clk); #3 rst_n = 1'b1;
      issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 3);
      wait_idle();

      repeat (300) begin
         rand_pair(a, b, op);
         model(a, b, op, r, f, l);
         issue(a, b, op, r, f, l);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Iterative single-precision floating-point add/subtract sequencer. It accepts one operand pair through a valid/ready handshake and compares exponents to pick the larger-magnitude operand. It aligns the smaller mantissa one bit per cycle, adds or subtracts, normalizes one bit per cycle, then holds the packed result until the consumer takes it. It sits between the operand-issue logic and the result writeback, and owns the whole add/sub datapath of the FP unit.

## Interface

- EXP_WIDTH, 8, exponent field width.
- MAN_WIDTH, 23, stored mantissa width; the hidden bit is implied.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE.
- op_a, op_b  in  EXP_WIDTH+MAN_WIDTH+1  IEEE-754 operands, laid out {sign, exp, man}.
- operation_select  in  1  1 = add (a+b), 0 = subtract (a−b); sampled with the operands.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  EXP_WIDTH+MAN_WIDTH+1  packed result; held stable while out_valid is high.
- flags  out  3  {underflow, invalid, overflow}; valid with result.
- busy  out  1  high whenever the state is not IDLE.

## Operation

- The FSM has five states: IDLE, ALIGN, ADD, NORM, DONE.
- Effective sign of b is sign_b XNOR operation_select.
- Denormal inputs (exp = 0) are flushed to signed zero on capture.
- Rounding is truncation (round toward zero). There are no guard bits.
- **IDLE** (in_ready = 1). On in_valid, register the operands.
  - Special case: if either exponent is all ones, the FSM goes straight to DONE.
    - Invalid: NaN input, or infinities of opposite effective sign. Result is 0x7FC00000 and flags[1] is set.
    - Otherwise the result is infinity with the sign of the infinite operand.
  - Normal case:
    - big = operand with the greater exponent; ties go to the larger mantissa, and full ties go to a.
    - shift count a = min(exp_big − exp_small, MAN_WIDTH+2).
    - Go to ALIGN if a > 0, else to ADD.
- **ALIGN**: small mantissa (with hidden bit) >>= 1 and count −= 1 each cycle. Go to ADD when the count reaches 0.
- **ADD**: operate on 25-bit (MAN_WIDTH+2) mantissas.
  - Equal effective signs: sum = big + small. Otherwise sum = big − small, which is never negative.
  - Result sign = effective sign of big.
  - sum = 0 gives result +0, and the FSM goes to DONE. This includes −0 + −0 = +0.
  - Carry bit set: shift right 1 and exp += 1.
    - If exp reaches all ones, the result is signed infinity, flags[0] is set, and the FSM goes to DONE.
    - Otherwise go to NORM.
- **NORM**: if the hidden bit is 1, pack the result and go to DONE.
  - Else if exp > 1, shift left 1 and exp −= 1.
  - Else flush to +0, set flags[2], and go to DONE.
- **DONE** (out_valid = 1): result and flags are held. On out_ready, go to IDLE.
- The block does not accept a new pair in the same cycle the result is taken, so the minimum cadence is one pair per (latency + 1) cycles.

## Timing

- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, busy = 0.
  - result = 0, flags = 0.
  - All internal registers cleared.
- Asserting rst_n in any state aborts the operation immediately. No result is produced and no handshake completes.
- Latency L is counted as cycles after the acceptance cycle until out_valid is first high. Let n = normalization left shifts.
  - Special operands: L = 1.
  - Zero result or overflow from ADD: L = a + 2.
  - General case: L = a + n + 3.
- Handshakes:
  - An input is accepted on a clock edge with in_valid & in_ready.
  - An output is consumed on a clock edge with out_valid & out_ready.
  - out_valid, once high, stays high with a stable result until consumed.
- in_ready is a pure decode of state, with no combinational path from in_valid.

## Test plan

- 0x3F800000 + 0x3F800000, op_sel=1 → 0x40000000, flags 0, L = 3, in_ready low throughout.
- 0x3F800000 − 0x3F800000, op_sel=0 → 0x00000000, L = 2. Then 0x3FC00000 − 0x3FA00000 → 0x3E800000, L = 5 (n = 2).
- 0x3F800000 + 0x30800000 (exponent difference 30, saturated to 25) → 0x3F800000, L = 28.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with flags[0] = 1, L = 2. 0x7F800000 + 0xFF800000 → 0x7FC00000 with flags[1] = 1, L = 1.
- Backpressure: hold out_ready low for 3 cycles after out_valid → result stable and in_ready = 0 throughout. Pulse out_ready → back to IDLE next cycle.
- Reset mid-operation: start 0x3F800000 + 0x30800000, then drop rst_n during ALIGN → outputs return to reset values asynchronously. After release, a fresh 1.0 + 1.0 yields 0x40000000 with L = 3.
